// File: rtl/multicycle_control_if.sv
// Datapath <-> controller bundle: instruction fields and memory status in,
// strobes, mux selects and status out.
interface multicycle_control_if #(
   parameter int ALUCTL_W = 4
);
   logic [5:0]          opcode;
   logic [5:0]          funct;
   logic                zero;
   logic                mem_ready;
   logic                pc_write;
   logic                ir_write;
   logic                mem_read;
   logic                mem_write;
   logic                reg_write;
   logic                i_or_d;
   logic                alu_src_a;
   logic                imm_zext;
   logic [1:0]          reg_dst;
   logic [1:0]          mem_to_reg;
   logic [1:0]          alu_src_b;
   logic [1:0]          pc_src;
   logic [ALUCTL_W-1:0] alu_ctl;
   logic                error;
   logic [3:0]          state;

   modport master (
      output opcode, funct, zero, mem_ready,
      input  pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d,
             alu_src_a, imm_zext, reg_dst, mem_to_reg, alu_src_b, pc_src,
             alu_ctl, error, state
   );

   modport slave (
      input  opcode, funct, zero, mem_ready,
      output pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d,
             alu_src_a, imm_zext, reg_dst, mem_to_reg, alu_src_b, pc_src,
             alu_ctl, error, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with memory wait timeout and sticky ERROR.
module multicycle_control #(
   parameter int ALUCTL_W = 4,
   parameter int WAIT_W   = 4,
   parameter int TIMEOUT  = 15
) (
   input logic                clk,
   input logic                rst,
   multicycle_control_if.slave bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
      MEM_ADDR = 4'd4, MEM_RD = 4'd5, MEM_WR = 4'd6, WB_R = 4'd7,
      WB_I = 4'd8, WB_MEM = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
      ERROR = 4'd15
   } state_e;

   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                          ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                          OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                          OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_LUI = 6'b001111;
   localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
   localparam logic [WAIT_W-1:0] WAIT_TO  = WAIT_W'(TIMEOUT);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [5:0]        op_q, fn_q;
   logic              waiting;
   logic [3:0]        ctl4;

   always_comb begin
      state_d = state_q;
      waiting = 1'b0;
      case (state_q)
         FETCH: begin
            waiting = 1'b1;
            if (bus.mem_ready)         state_d = DECODE;
            else if (wait_q == WAIT_TO) state_d = ERROR;
         end
         // DECODE looks at the live opcode; it is latched for later states.
         DECODE: begin
            case (bus.opcode)
               OP_R:                                      state_d = EXEC_R;
               OP_LW, OP_SW:                              state_d = MEM_ADDR;
               OP_BEQ, OP_BNE:                            state_d = BRANCH;
               OP_J, OP_JAL:                              state_d = JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = EXEC_I;
               default:                                   state_d = ERROR;
            endcase
         end
         EXEC_R: begin
            case (fn_q)
               6'b100000, 6'b100010, 6'b100100,
               6'b100101, 6'b100111, 6'b101010: state_d = WB_R;
               default:                         state_d = ERROR;
            endcase
         end
         EXEC_I:   state_d = WB_I;
         MEM_ADDR: state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            waiting = 1'b1;
            if (bus.mem_ready)         state_d = WB_MEM;
            else if (wait_q == WAIT_TO) state_d = ERROR;
         end
         MEM_WR: begin
            waiting = 1'b1;
            if (bus.mem_ready)         state_d = FETCH;
            else if (wait_q == WAIT_TO) state_d = ERROR;
         end
         WB_R, WB_I, WB_MEM, BRANCH, JUMP: state_d = FETCH;
         ERROR:   state_d = ERROR;
         default: state_d = ERROR;
      endcase

      wait_d = wait_q;
      if (state_d != state_q)                               wait_d = '0;
      else if (waiting && !bus.mem_ready && wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         wait_q  <= '0;
         op_q    <= '0;
         fn_q    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (state_q == DECODE) begin
            op_q <= bus.opcode;
            fn_q <= bus.funct;
         end
      end
   end

   always_comb begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.imm_zext   = 1'b0;
      bus.reg_dst    = 2'd0;
      bus.mem_to_reg = 2'd0;
      bus.alu_src_b  = 2'd0;
      bus.pc_src     = 2'd0;
      ctl4           = ALU_AND;
      case (state_q)
         FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'd1;
            ctl4          = ALU_ADD;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         DECODE: begin
            bus.alu_src_b = 2'd3;
            ctl4          = ALU_ADD;
         end
         EXEC_R: begin
            bus.alu_src_a = 1'b1;
            case (fn_q)
               6'b100000: ctl4 = ALU_ADD;
               6'b100010: ctl4 = ALU_SUB;
               6'b100100: ctl4 = ALU_AND;
               6'b100101: ctl4 = ALU_OR;
               6'b100111: ctl4 = ALU_NOR;
               6'b101010: ctl4 = ALU_SLT;
               default:   ctl4 = ALU_AND;
            endcase
         end
         WB_R: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 2'd1;
         end
         EXEC_I: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd2;
            bus.imm_zext  = (op_q == OP_ANDI) || (op_q == OP_ORI);
            case (op_q)
               OP_ANDI: ctl4 = ALU_AND;
               OP_ORI:  ctl4 = ALU_OR;
               OP_SLTI: ctl4 = ALU_SLT;
               default: ctl4 = ALU_ADD;
            endcase
         end
         WB_I: begin
            bus.reg_write  = 1'b1;
            bus.imm_zext   = (op_q == OP_ANDI) || (op_q == OP_ORI);
            bus.mem_to_reg = (op_q == OP_LUI) ? 2'd3 : 2'd0;
         end
         MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd2;
            ctl4          = ALU_ADD;
         end
         MEM_RD: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         WB_MEM: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 2'd1;
         end
         MEM_WR: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
         end
         BRANCH: begin
            bus.alu_src_a = 1'b1;
            ctl4          = ALU_SUB;
            bus.pc_src    = 2'd1;
            bus.pc_write  = (op_q == OP_BEQ) ? bus.zero : !bus.zero;
         end
         JUMP: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'd2;
            if (op_q == OP_JAL) begin
               bus.reg_write  = 1'b1;
               bus.reg_dst    = 2'd2;
               bus.mem_to_reg = 2'd2;
            end
         end
         default: ;
      endcase
   end

   assign bus.alu_ctl = ALUCTL_W'(ctl4);
   assign bus.error   = (state_q == ERROR);
   assign bus.state   = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one task per scenario, inline checks.
module tb_multicycle_control;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;

   multicycle_control_if #(.ALUCTL_W(4)) bus();

   multicycle_control #(.ALUCTL_W(4), .WAIT_W(4), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the first cycle after reset release (state FETCH).
   task automatic reset_dut();
      rst = 1'b1;
      bus.mem_ready = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      vecs++; if (bus.state !== 4'd0) begin errs++; $display("FAIL reset_state got %0d exp 0", bus.state); end
      vecs++; if (bus.error !== 1'b0) begin errs++; $display("FAIL reset_error got %b exp 0", bus.error); end
      vecs++; if (bus.mem_read !== 1'b1 || bus.alu_src_b !== 2'd1 || bus.alu_ctl !== 4'b0010)
         begin errs++; $display("FAIL reset_fetch_ctl got rd=%b srcb=%0d ctl=%b exp 1/1/0010", bus.mem_read, bus.alu_src_b, bus.alu_ctl); end
      vecs++; if (bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0)
         begin errs++; $display("FAIL reset_gate_lo got ir=%b pc=%b exp 0/0", bus.ir_write, bus.pc_write); end
      bus.mem_ready = 1'b1;
      #1;
      vecs++; if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1)
         begin errs++; $display("FAIL reset_gate_hi got ir=%b pc=%b exp 1/1", bus.ir_write, bus.pc_write); end
   endtask

   task automatic test_rtype();
      logic [3:0] exp [5];
      exp = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd0};
      reset_dut();
      bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         vecs++; if (bus.state !== exp[i]) begin errs++; $display("FAIL rtype_state[%0d] got %0d exp %0d", i, bus.state, exp[i]); end
         vecs++; if (bus.reg_write !== (exp[i] == 4'd7)) begin errs++; $display("FAIL rtype_regwr[%0d] got %b", i, bus.reg_write); end
         if (exp[i] == 4'd2) begin
            vecs++; if (bus.alu_ctl !== 4'b0010) begin errs++; $display("FAIL rtype_aluctl got %b exp 0010", bus.alu_ctl); end
         end
         if (exp[i] == 4'd7) begin
            vecs++; if (bus.reg_dst !== 2'd1) begin errs++; $display("FAIL rtype_regdst got %0d exp 1", bus.reg_dst); end
         end
         cyc();
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0] exp [9];
      logic       rdy [9];
      exp = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd9, 4'd0};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      reset_dut();
      bus.opcode = 6'b100011;
      for (int i = 0; i < 9; i++) begin
         bus.mem_ready = rdy[i];
         #1;
         vecs++; if (bus.state !== exp[i]) begin errs++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, bus.state, exp[i]); end
         vecs++; if (bus.error !== 1'b0) begin errs++; $display("FAIL lw_error[%0d] got %b exp 0", i, bus.error); end
         if (exp[i] == 4'd5) begin
            vecs++; if (bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b1)
               begin errs++; $display("FAIL lw_memrd[%0d] got rd=%b iord=%b exp 1/1", i, bus.mem_read, bus.i_or_d); end
         end
         if (exp[i] == 4'd9) begin
            vecs++; if (bus.mem_to_reg !== 2'd1 || bus.reg_write !== 1'b1)
               begin errs++; $display("FAIL lw_wbmem got m2r=%0d rw=%b exp 1/1", bus.mem_to_reg, bus.reg_write); end
         end
         cyc();
      end
   endtask

   task automatic test_branch();
      logic [5:0] ops [3];
      logic       zs  [3];
      logic       pw  [3];
      ops = '{6'b000100, 6'b000101, 6'b000100};
      zs  = '{1'b0, 1'b0, 1'b1};
      pw  = '{1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 3; k++) begin
         reset_dut();
         bus.opcode = ops[k]; bus.zero = zs[k]; bus.mem_ready = 1'b1;
         cyc(); cyc();
         #1;
         vecs++; if (bus.state !== 4'd10) begin errs++; $display("FAIL br_state[%0d] got %0d exp 10", k, bus.state); end
         vecs++; if (bus.pc_write !== pw[k]) begin errs++; $display("FAIL br_pcwrite[%0d] got %b exp %b", k, bus.pc_write, pw[k]); end
         vecs++; if (bus.pc_src !== 2'd1 || bus.alu_ctl !== 4'b0110)
            begin errs++; $display("FAIL br_ctl[%0d] got src=%0d ctl=%b exp 1/0110", k, bus.pc_src, bus.alu_ctl); end
         cyc();
         vecs++; if (bus.state !== 4'd0) begin errs++; $display("FAIL br_ret[%0d] got %0d exp 0", k, bus.state); end
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_jump();
      logic [5:0] ops [2];
      logic       rw  [2];
      ops = '{6'b000011, 6'b000010};
      rw  = '{1'b1, 1'b0};
      for (int k = 0; k < 2; k++) begin
         reset_dut();
         bus.opcode = ops[k]; bus.mem_ready = 1'b1;
         cyc(); cyc();
         #1;
         vecs++; if (bus.state !== 4'd11) begin errs++; $display("FAIL jmp_state[%0d] got %0d exp 11", k, bus.state); end
         vecs++; if (bus.pc_write !== 1'b1 || bus.pc_src !== 2'd2)
            begin errs++; $display("FAIL jmp_pc[%0d] got pw=%b src=%0d exp 1/2", k, bus.pc_write, bus.pc_src); end
         vecs++; if (bus.reg_write !== rw[k]) begin errs++; $display("FAIL jmp_regwr[%0d] got %b exp %b", k, bus.reg_write, rw[k]); end
         if (rw[k]) begin
            vecs++; if (bus.reg_dst !== 2'd2 || bus.mem_to_reg !== 2'd2)
               begin errs++; $display("FAIL jal_link got dst=%0d m2r=%0d exp 2/2", bus.reg_dst, bus.mem_to_reg); end
         end
      end
   endtask

   task automatic test_timeout();
      reset_dut();
      for (int i = 0; i < 16; i++) begin
         #1;
         vecs++; if (bus.state !== 4'd0) begin errs++; $display("FAIL to_wait[%0d] got %0d exp 0", i, bus.state); end
         cyc();
      end
      #1;
      vecs++; if (bus.state !== 4'd15 || bus.error !== 1'b1)
         begin errs++; $display("FAIL to_enter got st=%0d err=%b exp 15/1", bus.state, bus.error); end
      bus.mem_ready = 1'b1;
      cyc(); cyc();
      vecs++; if (bus.state !== 4'd15 || bus.error !== 1'b1 || bus.mem_read !== 1'b0 || bus.pc_write !== 1'b0)
         begin errs++; $display("FAIL to_sticky got st=%0d err=%b rd=%b pw=%b exp 15/1/0/0", bus.state, bus.error, bus.mem_read, bus.pc_write); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      vecs++; if (bus.state !== 4'd0 || bus.error !== 1'b0)
         begin errs++; $display("FAIL to_reset got st=%0d err=%b exp 0/0", bus.state, bus.error); end
   endtask

   task automatic test_timeout_edge();
      reset_dut();
      bus.opcode = 6'b000000; bus.funct = 6'b100000;
      for (int i = 0; i < 15; i++) cyc();
      bus.mem_ready = 1'b1;
      #1;
      vecs++; if (bus.state !== 4'd0 || bus.ir_write !== 1'b1)
         begin errs++; $display("FAIL edge_fetch got st=%0d ir=%b exp 0/1", bus.state, bus.ir_write); end
      cyc();
      vecs++; if (bus.state !== 4'd1 || bus.error !== 1'b0)
         begin errs++; $display("FAIL edge_decode got st=%0d err=%b exp 1/0", bus.state, bus.error); end
   endtask

   task automatic test_illegal();
      logic [5:0] ops [2];
      logic [5:0] fns [2];
      logic [3:0] exp [2][4];
      ops = '{6'b111111, 6'b000000};
      fns = '{6'b100000, 6'b000001};
      exp = '{'{4'd0, 4'd1, 4'd15, 4'd15}, '{4'd0, 4'd1, 4'd2, 4'd15}};
      for (int k = 0; k < 2; k++) begin
         reset_dut();
         bus.opcode = ops[k]; bus.funct = fns[k]; bus.mem_ready = 1'b1;
         for (int i = 0; i < 4; i++) begin
            #1;
            vecs++; if (bus.state !== exp[k][i]) begin errs++; $display("FAIL ill_state[%0d][%0d] got %0d exp %0d", k, i, bus.state, exp[k][i]); end
            vecs++; if (bus.reg_write !== 1'b0) begin errs++; $display("FAIL ill_regwr[%0d][%0d] got %b exp 0", k, i, bus.reg_write); end
            cyc();
         end
      end
   endtask

   // sw, ori, lui, slti issued with no reset in between.
   task automatic test_back_to_back();
      logic [5:0] ops [4];
      logic [3:0] exp [4][4];
      logic [3:0] ctl [4];
      logic [1:0] m2r [4];
      logic       zx  [4];
      ops = '{6'b101011, 6'b001101, 6'b001111, 6'b001010};
      exp = '{'{4'd0, 4'd1, 4'd4, 4'd6}, '{4'd0, 4'd1, 4'd3, 4'd8},
              '{4'd0, 4'd1, 4'd3, 4'd8}, '{4'd0, 4'd1, 4'd3, 4'd8}};
      ctl = '{4'b0010, 4'b0001, 4'b0010, 4'b0111};
      m2r = '{2'd0, 2'd0, 2'd3, 2'd0};
      zx  = '{1'b0, 1'b1, 1'b0, 1'b0};
      reset_dut();
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.opcode = ops[k];
         for (int i = 0; i < 4; i++) begin
            #1;
            vecs++; if (bus.state !== exp[k][i]) begin errs++; $display("FAIL b2b_state[%0d][%0d] got %0d exp %0d", k, i, bus.state, exp[k][i]); end
            if (i == 2) begin
               vecs++; if (bus.alu_ctl !== ctl[k]) begin errs++; $display("FAIL b2b_aluctl[%0d] got %b exp %b", k, bus.alu_ctl, ctl[k]); end
            end
            if (exp[k][i] == 4'd6) begin
               vecs++; if (bus.mem_write !== 1'b1 || bus.i_or_d !== 1'b1)
                  begin errs++; $display("FAIL b2b_memwr got wr=%b iord=%b exp 1/1", bus.mem_write, bus.i_or_d); end
            end
            if (exp[k][i] == 4'd8) begin
               vecs++; if (bus.mem_to_reg !== m2r[k] || bus.imm_zext !== zx[k] || bus.reg_write !== 1'b1 || bus.reg_dst !== 2'd0)
                  begin errs++; $display("FAIL b2b_wbi[%0d] got m2r=%0d zext=%b rw=%b dst=%0d exp %0d/%b/1/0", k, bus.mem_to_reg, bus.imm_zext, bus.reg_write, bus.reg_dst, m2r[k], zx[k]); end
            end
            cyc();
         end
      end
   endtask

   initial begin
      bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branch();
      test_jump();
      test_timeout();
      test_timeout_edge();
      test_illegal();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUCTL_W, default 4: width of alu_ctl; values above 4 are zero-extended from the 4-bit codes in REQ-020.
REQ-002 Parameter WAIT_W, default 4: width of the memory wait counter.
REQ-003 Parameter TIMEOUT, default 15: number of wait cycles without mem_ready after which the block enters ERROR; must be at most 2^WAIT_W-1.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 opcode  in  6  instruction[31:26]; valid from the cycle after the FETCH accept.
REQ-007 funct  in  6  instruction[5:0]; same validity as opcode.
REQ-008 zero  in  1  ALU zero flag; sampled in BRANCH only.
REQ-009 mem_ready  in  1  memory completion for the current access.
REQ-010 pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a, imm_zext  out  1 each  datapath strobes and selects.
REQ-011 reg_dst  out  2  0=rt, 1=rd, 2=$31.
REQ-012 mem_to_reg  out  2  0=ALU, 1=MDR, 2=PC, 3=imm<<16.
REQ-013 alu_src_b  out  2  0=B, 1=4, 2=ext imm, 3=sext imm<<2.
REQ-014 pc_src  out  2  0=ALU, 1=ALUOut, 2=jump target.
REQ-015 alu_ctl  out  ALUCTL_W  ALU operation.
REQ-016 error  out  1  sticky fault flag.
REQ-017 state  out  4  current state encoding.

Function
REQ-018 States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10, JUMP=11, ERROR=15.
REQ-019 Outputs are Moore, decoded from state and the held opcode/funct; BRANCH pc_write is the only output that also depends on zero. Every strobe not listed for a state is 0.
REQ-020 alu_ctl codes: and=0000, or=0001, add=0010, sub=0110, slt=0111, nor=1100.
REQ-021 FETCH:
- mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_ctl=add, pc_src=0.
- ir_write and pc_write are asserted only in the cycle mem_ready=1; that cycle the state moves to DECODE.
REQ-022 DECODE: alu_src_a=0, alu_src_b=3, alu_ctl=add. Next state by opcode:
- 000000 -> EXEC_R
- 100011 and 101011 -> MEM_ADDR
- 000100 and 000101 -> BRANCH
- 000010 and 000011 -> JUMP
- 001000, 001100, 001101, 001010, 001111 -> EXEC_I
- any other opcode -> ERROR
REQ-023 EXEC_R: alu_src_a=1, alu_src_b=0; alu_ctl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt; any other funct -> ERROR, else -> WB_R.
REQ-024 WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-025 EXEC_I: alu_src_a=1, alu_src_b=2; alu_ctl is add for addi/lui, and for andi, or for ori, slt for slti; imm_zext=1 for andi/ori only; next state WB_I.
REQ-026 WB_I: reg_write=1, reg_dst=0, imm_zext held as in EXEC_I; mem_to_reg=3 for lui, 0 otherwise; next state FETCH.
REQ-027 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_ctl=add; next state MEM_RD for lw, MEM_WR for sw.
REQ-028 MEM_RD: mem_read=1, i_or_d=1; goes to WB_MEM on mem_ready. WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-029 MEM_WR: mem_write=1, i_or_d=1; goes to FETCH on mem_ready.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=0, alu_ctl=sub, pc_src=1; pc_write=zero for beq, !zero for bne; next state FETCH.
REQ-031 JUMP: pc_write=1, pc_src=2; jal additionally drives reg_write=1, reg_dst=2, mem_to_reg=2; next state FETCH.
REQ-032 Wait counter:
- Cleared on every state entry.
- Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0, saturating at 2^WAIT_W-1.
- When the counter equals TIMEOUT with mem_ready=0, the next state is ERROR; mem_ready=1 in that same cycle takes priority.
REQ-033 ERROR: all strobes 0, error=1, state=15; held until rst.
REQ-034 Latency with mem_ready tied to 1: R-type/I-type 4 cycles, lw 5, sw 4, beq/bne 3, j/jal 3.

Reset
REQ-035 rst=1 at posedge forces state FETCH, wait counter 0, error 0; this overrides any in-flight state, including a pending memory access and ERROR.
REQ-036 The cycle after reset deasserts, outputs are the FETCH values, with ir_write/pc_write gated by mem_ready.

Verification
REQ-037 add (opcode 000000, funct 100000), mem_ready=1 -> states 0,1,2,7,0; alu_ctl=0010 in EXEC_R; reg_write=1 with reg_dst=1 in WB_R only.
REQ-038 lw with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles; WB_MEM follows with mem_to_reg=1; no error.
REQ-039 beq with zero=0 -> pc_write=0 in BRANCH; bne with zero=0 -> pc_write=1, pc_src=1.
REQ-040 jal -> JUMP asserts pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2.
REQ-041 mem_ready held 0 in FETCH -> ERROR entered after 16 cycles (TIMEOUT=15); error=1 sticky; rst -> state 0, error 0.
REQ-042 opcode 111111 or funct 000001 -> ERROR from DECODE or EXEC_R; reg_write never asserted.
